// File: rtl/conv_seq_pkg.sv
// Shared state encoding and geometry helpers for the convolution layer sequencer.
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } seq_state_e;

  function automatic int calc_wpg(input int pof, input int nkx, input int nky);
    return pof * nkx * nky;
  endfunction

  function automatic int calc_frame(input int image_width);
    return image_width * image_width;
  endfunction

endpackage

// File: rtl/conv_seq_weight_fetch.sv
// Weight fetch engine: issues one read per cycle for the current group and
// re-registers each returned word as a core weight-buffer write.
module conv_seq_weight_fetch
  import conv_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int POF        = 4,
  parameter int NKX        = 3,
  parameter int NKY        = 3,
  parameter int NUM_GROUPS = 8
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  start_i,
  input  logic                                                  active_i,
  input  logic [$clog2(NUM_GROUPS+1)-1:0]                       group_i,
  output logic                                                  wmem_req_o,
  output logic [$clog2(NUM_GROUPS*calc_wpg(POF, NKX, NKY))-1:0] wmem_addr_o,
  input  logic                                                  wmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                                 wmem_rdata_i,
  output logic                                                  core_load_weights_o,
  output logic [$clog2(calc_wpg(POF, NKX, NKY))-1:0]            core_weight_addr_o,
  output logic [DATA_WIDTH-1:0]                                 core_weight_in_o,
  output logic                                                  last_o
);

  localparam int WPG = calc_wpg(POF, NKX, NKY);
  localparam int AW  = $clog2(NUM_GROUPS * WPG);
  localparam int CW  = $clog2(WPG);
  localparam int RW  = $clog2(WPG + 1);

  logic [RW-1:0]         req_cnt_q, req_cnt_d;
  logic [RW-1:0]         rx_cnt_q, rx_cnt_d;
  logic                  wr_q, wr_d;
  logic [CW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rx_take;

  assign wmem_req_o  = active_i && (req_cnt_q < RW'(WPG));
  assign wmem_addr_o = wmem_req_o ? AW'(int'(group_i) * WPG + int'(req_cnt_q)) : '0;

  // Returns outside LOAD, or beyond the group's word count, never reach the core.
  assign rx_take = active_i && wmem_rvalid_i && (rx_cnt_q < RW'(WPG));

  always_comb begin
    req_cnt_d = req_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    wr_d      = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (start_i) begin
      req_cnt_d = '0;
      rx_cnt_d  = '0;
    end else begin
      if (wmem_req_o) begin
        req_cnt_d = req_cnt_q + RW'(1);
      end
      if (rx_take) begin
        wr_d      = 1'b1;
        wr_addr_d = CW'(rx_cnt_q);
        wr_data_d = wmem_rdata_i;
        rx_cnt_d  = rx_cnt_q + RW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_cnt_q <= '0;
      rx_cnt_q  <= '0;
      wr_q      <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      req_cnt_q <= req_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      wr_q      <= wr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign core_load_weights_o = wr_q;
  assign core_weight_addr_o  = wr_addr_q;
  assign core_weight_in_o    = wr_data_q;
  assign last_o              = wr_q && (wr_addr_q == CW'(WPG - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Layer controller: per filter group resets the core, loads its weights and streams one frame.
// Optional stall counter enabled by defining SEQ_PERF_CNT_EN.
module conv_layer_sequencer
  import conv_seq_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_WIDTH = 640,
  parameter int POF         = 4,
  parameter int NKX         = 3,
  parameter int NKY         = 3,
  parameter int NUM_GROUPS  = 8
) (
  input  logic                                                  clk,
  input  logic                                                  rst,
  input  logic                                                  cmd_valid,
  output logic                                                  cmd_ready,
  input  logic [$clog2(NUM_GROUPS+1)-1:0]                       cmd_num_groups,
  output logic                                                  wmem_req,
  output logic [$clog2(NUM_GROUPS*calc_wpg(POF, NKX, NKY))-1:0] wmem_addr,
  input  logic                                                  wmem_rvalid,
  input  logic [DATA_WIDTH-1:0]                                 wmem_rdata,
  output logic                                                  core_rst,
  output logic                                                  core_load_weights,
  output logic [$clog2(calc_wpg(POF, NKX, NKY))-1:0]            core_weight_addr,
  output logic [DATA_WIDTH-1:0]                                 core_weight_in,
  input  logic                                                  pix_valid_in,
  output logic                                                  pix_ready_out,
  output logic                                                  core_pixel_valid,
  input  logic                                                  core_done,
  output logic [$clog2(NUM_GROUPS+1)-1:0]                       group_idx,
  output logic                                                  busy,
  output logic                                                  layer_done,
  output logic [31:0]                                           perf_stall_cycles
);

  localparam int FRAME = calc_frame(IMAGE_WIDTH);
  localparam int GW    = $clog2(NUM_GROUPS + 1);
  localparam int PW    = $clog2(FRAME);

  seq_state_e    state_q, state_d;
  logic [GW-1:0] num_q, num_d;
  logic [GW-1:0] group_q, group_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic          cmd_accept;
  logic          fetch_start;
  logic          fetch_active;
  logic          fetch_last;

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = !cmd_ready;
  assign cmd_accept       = cmd_ready && cmd_valid && (cmd_num_groups != '0);
  assign core_pixel_valid = pix_valid_in && pix_ready_out;
  assign group_idx        = group_q;

  always_comb begin
    state_d       = state_q;
    num_d         = num_q;
    group_d       = group_q;
    pix_cnt_d     = pix_cnt_q;
    core_rst      = 1'b0;
    fetch_start   = 1'b0;
    fetch_active  = 1'b0;
    pix_ready_out = 1'b0;
    layer_done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          num_d   = (cmd_num_groups > GW'(NUM_GROUPS)) ? GW'(NUM_GROUPS) : cmd_num_groups;
          group_d = '0;
          state_d = CLR;
        end
      end
      CLR: begin
        core_rst    = 1'b1;
        fetch_start = 1'b1;
        pix_cnt_d   = '0;
        state_d     = LOAD;
      end
      LOAD: begin
        fetch_active = 1'b1;
        if (fetch_last) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        pix_ready_out = 1'b1;
        if (pix_valid_in) begin
          if (pix_cnt_q == PW'(FRAME - 1)) begin
            state_d = DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + PW'(1);
          end
        end
      end
      DRAIN: begin
        if (core_done) begin
          if (group_q == num_q - GW'(1)) begin
            state_d = DONE;
          end else begin
            group_d = group_q + GW'(1);
            state_d = CLR;
          end
        end
      end
      DONE: begin
        layer_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      num_q     <= '0;
      group_q   <= '0;
      pix_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      num_q     <= num_d;
      group_q   <= group_d;
      pix_cnt_q <= pix_cnt_d;
    end
  end

  conv_seq_weight_fetch #(
    .DATA_WIDTH (DATA_WIDTH),
    .POF        (POF),
    .NKX        (NKX),
    .NKY        (NKY),
    .NUM_GROUPS (NUM_GROUPS)
  ) u_weight_fetch (
    .clk_i               (clk),
    .rst_i               (rst),
    .start_i             (fetch_start),
    .active_i            (fetch_active),
    .group_i             (group_q),
    .wmem_req_o          (wmem_req),
    .wmem_addr_o         (wmem_addr),
    .wmem_rvalid_i       (wmem_rvalid),
    .wmem_rdata_i        (wmem_rdata),
    .core_load_weights_o (core_load_weights),
    .core_weight_addr_o  (core_weight_addr),
    .core_weight_in_o    (core_weight_in),
    .last_o              (fetch_last)
  );

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Counts starved STREAM cycles for the layer; saturates rather than wrapping.
  always_comb begin
    perf_d = perf_q;
    if (cmd_accept) begin
      perf_d = '0;
    end else if ((state_q == STREAM) && !pix_valid_in && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_stall_cycles = perf_q;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Scoreboard bench for conv_layer_sequencer with a 3-cycle data=address weight memory.
`timescale 1ns/1ps
module tb_conv_layer_sequencer;

  localparam int DW      = 16;
  localparam int IW      = 4;
  localparam int POF     = 2;
  localparam int NKX     = 3;
  localparam int NKY     = 3;
  localparam int NG      = 8;
  localparam int WPG     = 18;
  localparam int FRAME   = 16;
  localparam int GW      = 4;
  localparam int AW      = 8;
  localparam int CW      = 5;
  localparam int MEM_LAT = 3;
`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF_EN = 1'b1;
`else
  localparam bit PERF_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [GW-1:0] cmd_num_groups = '0;
  logic          wmem_req;
  logic [AW-1:0] wmem_addr;
  logic          wmem_rvalid;
  logic [DW-1:0] wmem_rdata;
  logic          core_rst;
  logic          core_load_weights;
  logic [CW-1:0] core_weight_addr;
  logic [DW-1:0] core_weight_in;
  logic          pix_valid_in;
  logic          pix_ready_out;
  logic          core_pixel_valid;
  logic          core_done;
  logic [GW-1:0] group_idx;
  logic          busy;
  logic          layer_done;
  logic [31:0]   perf_stall_cycles;

  conv_layer_sequencer #(
    .DATA_WIDTH (DW),
    .IMAGE_WIDTH(IW),
    .POF        (POF),
    .NKX        (NKX),
    .NKY        (NKY),
    .NUM_GROUPS (NG)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_num_groups    (cmd_num_groups),
    .wmem_req          (wmem_req),
    .wmem_addr         (wmem_addr),
    .wmem_rvalid       (wmem_rvalid),
    .wmem_rdata        (wmem_rdata),
    .core_rst          (core_rst),
    .core_load_weights (core_load_weights),
    .core_weight_addr  (core_weight_addr),
    .core_weight_in    (core_weight_in),
    .pix_valid_in      (pix_valid_in),
    .pix_ready_out     (pix_ready_out),
    .core_pixel_valid  (core_pixel_valid),
    .core_done         (core_done),
    .group_idx         (group_idx),
    .busy              (busy),
    .layer_done        (layer_done),
    .perf_stall_cycles (perf_stall_cycles)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nCompared = 0;
  int nMismatch = 0;

  // Scoreboard queues filled by applyStimulus, drained by the monitor.
  logic [AW-1:0] aq[$];
  logic [CW-1:0] waq[$];
  logic [DW-1:0] wdq[$];
  logic [GW-1:0] rq[$];
  int            dPix[$];
  int            dStall[$];
  int            dGroups[$];

  int pixMode     = 0;
  int streamStart = 0;
  bit holdDone    = 1'b0;
  bit doneArmed   = 1'b0;
  int doneAt      = 0;
  int groupHs     = 0;
  int pixSeen     = 0;
  int groupsSeen  = 0;
  int doneCount   = 0;
  bit sawWord7    = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Weight memory: fixed latency, returns data equal to the requested address.
  initial begin
    logic          reqSeen;
    logic [AW-1:0] addrSeen;
    logic          pv[MEM_LAT];
    logic [AW-1:0] pa[MEM_LAT];
    for (int i = 0; i < MEM_LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    wmem_rvalid = 1'b0;
    wmem_rdata  = '0;
    forever begin
      @(negedge clk);
      reqSeen  = wmem_req;
      addrSeen = wmem_addr;
      @(posedge clk);
      #1;
      for (int i = MEM_LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = reqSeen;
      pa[0] = addrSeen;
      wmem_rvalid = pv[MEM_LAT-1];
      wmem_rdata  = pv[MEM_LAT-1] ? DW'(pa[MEM_LAT-1]) : '0;
    end
  end

  // Pixel source and core model; core_done is a level cleared by core_rst.
  initial begin
    pix_valid_in = 1'b0;
    core_done    = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (pixMode)
        1:       pix_valid_in = 1'b1;
        2:       pix_valid_in = (cyc >= streamStart) && (((cyc - streamStart) % 2) == 1);
        default: pix_valid_in = 1'b0;
      endcase
      core_done = holdDone || (doneArmed && (cyc >= doneAt));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wmem_req) begin
          if (aq.size() == 0) checkOutput("unexpected_wmem_req", wmem_req, 0);
          else checkOutput("wmem_addr", wmem_addr, aq.pop_front());
        end
        if (core_load_weights) begin
          checkOutput("load_vs_ready", pix_ready_out, 0);
          if (core_weight_addr == CW'(7)) sawWord7 = 1'b1;
          if (waq.size() == 0) begin
            checkOutput("unexpected_core_write", core_load_weights, 0);
          end else begin
            checkOutput("core_weight_addr", core_weight_addr, waq.pop_front());
            checkOutput("core_weight_in", core_weight_in, wdq.pop_front());
          end
        end
        if (core_rst) begin
          groupsSeen++;
          groupHs   = 0;
          doneArmed = 1'b0;
          if (rq.size() == 0) checkOutput("unexpected_core_rst", core_rst, 0);
          else checkOutput("group_idx_at_core_rst", group_idx, rq.pop_front());
        end
        if (core_pixel_valid) begin
          pixSeen++;
          groupHs++;
          if (groupHs == FRAME) begin
            doneAt    = cyc + (holdDone ? 1 : 3);
            doneArmed = 1'b1;
          end
        end
        if (layer_done) begin
          if (dPix.size() == 0) begin
            checkOutput("unexpected_layer_done", layer_done, 0);
          end else begin
            checkOutput("pixel_handshakes", pixSeen, dPix.pop_front());
            checkOutput("groups_run", groupsSeen, dGroups.pop_front());
            checkOutput("perf_stall_cycles", perf_stall_cycles, dStall.pop_front());
            checkOutput("layer_done_latency", cyc, doneAt + 1);
          end
          pixSeen    = 0;
          groupsSeen = 0;
          doneCount++;
        end
      end
    end
  end

  // Toggle mode starts low on the first STREAM cycle: CLR, 18 requests, 3-cycle memory, write stage.
  task automatic applyStimulus(input logic [GW-1:0] numReq, input int mode, input bit hold);
    int n;
    n = (int'(numReq) > NG) ? NG : int'(numReq);
    for (int g = 0; g < n; g++) begin
      rq.push_back(GW'(g));
      for (int i = 0; i < WPG; i++) begin
        aq.push_back(AW'(g * WPG + i));
        waq.push_back(CW'(i));
        wdq.push_back(DW'(g * WPG + i));
      end
    end
    if (n > 0) begin
      dPix.push_back(n * FRAME);
      dGroups.push_back(n);
      dStall.push_back((PERF_EN && mode == 2) ? FRAME : 0);
    end
    @(posedge clk);
    #1;
    pixMode        = mode;
    holdDone       = hold;
    streamStart    = cyc + 2 + WPG + MEM_LAT + 1;
    cmd_valid      = 1'b1;
    cmd_num_groups = numReq;
    @(posedge clk);
    #1;
    cmd_valid      = 1'b0;
    cmd_num_groups = '0;
  endtask

  task automatic waitLayerDone(input int target, input int budget);
    int k;
    k = 0;
    while ((doneCount < target) && (k < budget)) begin
      @(posedge clk);
      k++;
    end
    checkOutput("layer_done_count", doneCount, target);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_core_rst"}, core_rst, 0);
    checkOutput({tag, "_wmem_req"}, wmem_req, 0);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_wmem_req"}, wmem_req, 0);
    checkOutput({tag, "_wmem_addr"}, wmem_addr, 0);
    checkOutput({tag, "_core_rst"}, core_rst, 0);
    checkOutput({tag, "_core_load_weights"}, core_load_weights, 0);
    checkOutput({tag, "_core_weight_addr"}, core_weight_addr, 0);
    checkOutput({tag, "_core_weight_in"}, core_weight_in, 0);
    checkOutput({tag, "_pix_ready_out"}, pix_ready_out, 0);
    checkOutput({tag, "_core_pixel_valid"}, core_pixel_valid, 0);
    checkOutput({tag, "_group_idx"}, group_idx, 0);
    checkOutput({tag, "_layer_done"}, layer_done, 0);
    checkOutput({tag, "_perf"}, perf_stall_cycles, 0);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetState("reset");

    $display("[TB] single group, continuous pixels");
    applyStimulus(4'd1, 1, 1'b0);
    waitLayerDone(1, 400);
    checkIdle("after_n1");

    $display("[TB] three groups");
    applyStimulus(4'd3, 1, 1'b0);
    waitLayerDone(2, 800);
    checkIdle("after_n3");

    $display("[TB] toggling pixel valid");
    applyStimulus(4'd1, 2, 1'b0);
    waitLayerDone(3, 400);
    checkIdle("after_toggle");

    $display("[TB] zero-group command");
    @(posedge clk);
    #1;
    cmd_valid      = 1'b1;
    cmd_num_groups = '0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkIdle("zero_groups");
    checkIdle("zero_groups_later");

    $display("[TB] oversized command clamps to NUM_GROUPS");
    applyStimulus(4'd15, 1, 1'b0);
    waitLayerDone(4, 2000);
    checkIdle("after_n15");

    $display("[TB] reset during weight load");
    sawWord7 = 1'b0;
    applyStimulus(4'd2, 1, 1'b0);
    k = 0;
    while (!sawWord7 && (k < 100)) begin
      @(negedge clk);
      #1;
      k++;
    end
    checkOutput("word7_reached", sawWord7, 1);
    rst = 1'b1;
    aq.delete();
    waq.delete();
    wdq.delete();
    rq.delete();
    dPix.delete();
    dStall.delete();
    dGroups.delete();
    pixSeen    = 0;
    groupsSeen = 0;
    doneArmed  = 1'b0;
    @(negedge clk);
    checkResetState("abort");
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    checkOutput("no_layer_done_after_abort", doneCount, 4);
    applyStimulus(4'd1, 1, 1'b0);
    waitLayerDone(5, 400);
    checkIdle("after_abort_recovery");

    $display("[TB] core_done held high before DRAIN");
    applyStimulus(4'd1, 1, 1'b1);
    waitLayerDone(6, 400);
    holdDone = 1'b0;
    checkIdle("after_hold_done");

    repeat (5) @(posedge clk);
    checkOutput("pending_wmem_addr", aq.size(), 0);
    checkOutput("pending_core_writes", waq.size(), 0);
    checkOutput("pending_core_rst", rq.size(), 0);
    checkOutput("pending_layer_done", dPix.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Layer-level controller that sequences the convolution core through multiple output-filter groups. Per group it pulses a core reset, fetches that group's POF×NKX×NKY weights from an external weight memory into the core's weight buffer, then gates a full IMAGE_WIDTH×IMAGE_WIDTH pixel frame into the core. It waits for the core's done flag and repeats for the next group until the commanded group count is exhausted. It sits between the host/DMA command path and the core's weight-load and pixel-input interfaces.

## Interface
- DATA_WIDTH, 16, pixel/weight width
- IMAGE_WIDTH, 640, square frame side; frame = IMAGE_WIDTH² pixels
- POF, 4, filters per group
- NKX / NKY, 3 / 3, kernel dims; WPG = POF·NKX·NKY weights per group
- NUM_GROUPS, 8, max groups per command; GW = $clog2(NUM_GROUPS+1)
- clk  in  1  rising-edge clock (single domain)
- rst  in  1  synchronous, active-high reset
- cmd_valid / cmd_ready  in / out  1  command handshake; cmd_ready = (state==IDLE)
- cmd_num_groups  in  GW  groups to run
- wmem_req  out  1  weight read request, one word per cycle
- wmem_addr  out  $clog2(NUM_GROUPS·WPG)  read address
- wmem_rvalid / wmem_rdata  in  1 / DATA_WIDTH  in-order read return, any fixed latency ≥1
- core_rst  out  1  core counter reset pulse
- core_load_weights  out  1  core weight write enable
- core_weight_addr  out  $clog2(WPG)  core weight address
- core_weight_in  out  DATA_WIDTH  core weight data
- pix_valid_in / pix_ready_out  in / out  1  upstream pixel handshake
- core_pixel_valid  out  1  = pix_valid_in & pix_ready_out
- core_done  in  1  core frame-complete level
- group_idx  out  GW  current group
- busy  out  1  state≠IDLE
- layer_done  out  1  one-cycle completion pulse
- perf_stall_cycles  out  32  starvation counter (see Configuration)

## Operation
- States: IDLE → CLR → LOAD → STREAM → DRAIN → (CLR | DONE) → IDLE.
- IDLE: on cmd_valid&cmd_ready latch N = min(cmd_num_groups, NUM_GROUPS), group_idx=0, → CLR. N=0: no transfer (cmd_ready stays 1, state unchanged).
- CLR: core_rst=1 for exactly one cycle; zero req/rx counters; → LOAD.
- LOAD: wmem_req=1 each cycle until WPG requests issued; wmem_addr = group_idx·WPG + req_cnt. Each wmem_rvalid registers core_load_weights=1, core_weight_addr=rx_cnt, core_weight_in=wmem_rdata next cycle; rx_cnt++. Go to STREAM on the cycle after the registered write of word WPG-1 is presented. Extra rvalid outside LOAD is ignored.
- STREAM: pix_ready_out=1; count handshakes; after the IMAGE_WIDTH²-th, pix_ready_out drops the next cycle, → DRAIN.
- DRAIN: pix_ready_out=0; on core_done=1: if group_idx==N-1 → DONE, else group_idx++ → CLR. core_done is never sampled outside DRAIN.
- DONE: layer_done=1 one cycle, → IDLE.
- pix_ready_out and core_load_weights are never both 1.

## Timing
- Reset: state IDLE; cmd_ready=1 from the first cycle after reset; all other outputs 0, counters 0.
- rst mid-operation aborts at once to IDLE; no layer_done is issued; pixels in flight are dropped.
- core_rst asserts the cycle after command acceptance.
- Weight path latency: rvalid → core write = 1 cycle.
- Minimum per-group overhead excluding memory latency: 1 (CLR) + WPG + 1 + 1 cycles.
- layer_done occurs 1 cycle after core_done is seen in DRAIN for the last group.

## Configuration
- SEQ_PERF_CNT_EN defined: perf_stall_cycles counts STREAM cycles with pix_ready_out=1 and pix_valid_in=0. Cleared on command accept, saturates at 2³²-1, holds after DONE.
- Not defined: perf_stall_cycles tied to 0; no counter logic.

## Structure
- Package conv_seq_pkg: state enum (IDLE, CLR, LOAD, STREAM, DRAIN, DONE), WPG and frame-size localparam functions.
- One sub-module, conv_seq_weight_fetch: request/return counters and the registered core-write stage. The FSM starts it and receives a last-word indication back.

## Test plan
All scenarios use IMAGE_WIDTH=4, POF=2, NKX=NKY=3 (WPG=18, frame=16), and a memory model with 3-cycle latency whose data = address.
- N=1, continuous pixels → one core_rst; 18 core writes with addr 0..17, data 0..17; 16 pixel handshakes; layer_done 1 cycle after core_done.
- N=3 → wmem_addr ranges 0–17, 18–35, 36–53; three core_rst pulses; group_idx steps 0,1,2; exactly one layer_done.
- pix_valid_in toggling 1/0 → exactly 16 handshakes per group; perf_stall_cycles=16 with SEQ_PERF_CNT_EN, 0 without.
- cmd_num_groups=0 → no state change, cmd_ready=1. cmd_num_groups=15 with NUM_GROUPS=8 → 8 groups run.
- rst asserted mid-LOAD at word 7 → next cycle IDLE, cmd_ready=1, all other outputs 0, no layer_done; a new command then completes normally.
- core_done held high through CLR/LOAD/STREAM → ignored until DRAIN; pixel count is still exactly 16.
